// File: rtl/byte_unstriping.sv
// rtl/byte_unstriping.sv - 4-lane word de-striper: word FIFO feeding a lane0-first byte serializer
//
// Ports:
//   clk1Mhz            system clock, all state on the rising edge
//   reset              synchronous active-high reset, dominates every other input
//   stripedLane0..3    lane bytes of one word (stream bytes 4n+0 .. 4n+3)
//   stripedVLD         the lanes carry a word this cycle
//   laneRDY            a word can be accepted this cycle (FIFO not full)
//   byteUnstripingOUT  reassembled byte stream (registered)
//   byteUnstripingVLD  byteUnstripingOUT valid (registered)
//   overflowERR        sticky: a word was offered while laneRDY was low
module byte_unstriping #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk1Mhz,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] stripedLane0,
    input  logic [DATA_WIDTH-1:0] stripedLane1,
    input  logic [DATA_WIDTH-1:0] stripedLane2,
    input  logic [DATA_WIDTH-1:0] stripedLane3,
    input  logic                  stripedVLD,
    output logic                  laneRDY,
    output logic [DATA_WIDTH-1:0] byteUnstripingOUT,
    output logic                  byteUnstripingVLD,
    output logic                  overflowERR
);

    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W = 4 * DATA_WIDTH;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // ------------------------------------------------------------------
    // Word FIFO. Lane0 sits in the low byte so the serializer can shift
    // the word right one byte per clock.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] head_word;

    assign in_word    = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
    assign head_word  = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign laneRDY    = (count != (AW + 1)'(FIFO_DEPTH));
    assign push       = stripedVLD & laneRDY;

    // Storage carries no reset: contents are only meaningful under count.
    always_ff @(posedge clk1Mhz) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    // Pointers are power-of-two wide, so natural overflow gives the wrap.
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflowERR <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // A word offered while full is dropped; the FIFO stays untouched.
            if (stripedVLD && !laneRDY) begin
                overflowERR <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer. cnt holds the index of the next lane to drive; in SEND
    // cnt==0 means lane3 has just gone out, so this edge either loads the
    // next word (no bubble) or returns to IDLE.
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nx;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nx;
    logic [DATA_WIDTH-1:0] out_nx;
    logic              vld_nx;
    logic              word_done;

    assign word_done = (state == IDLE) || (cnt == 2'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        out_nx   = '0;
        vld_nx   = 1'b0;
        pop      = 1'b0;

        if (word_done) begin
            if (!fifo_empty) begin
                // Pop reads the registered head, so a word written on this
                // same edge can never be emitted on it.
                pop      = 1'b1;
                out_nx   = head_word[DATA_WIDTH-1:0];
                shreg_nx = head_word >> DATA_WIDTH;
                vld_nx   = 1'b1;
                cnt_nx   = 2'd1;
                state_nx = SEND;
            end else begin
                cnt_nx   = 2'd0;
                state_nx = IDLE;
            end
        end else begin
            out_nx   = shreg[DATA_WIDTH-1:0];
            shreg_nx = shreg >> DATA_WIDTH;
            vld_nx   = 1'b1;
            cnt_nx   = cnt + 2'd1;
        end
    end

    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= 2'd0;
            shreg             <= '0;
            byteUnstripingOUT <= '0;
            byteUnstripingVLD <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            shreg             <= shreg_nx;
            byteUnstripingOUT <= out_nx;
            byteUnstripingVLD <= vld_nx;
        end
    end

endmodule

// File: tb/tb_byte_unstriping.sv
// tb/tb_byte_unstriping.sv - self-checking bench for byte_unstriping
module tb_byte_unstriping;

    logic       clk1Mhz = 1'b0;
    logic       reset;
    logic [7:0] stripedLane0, stripedLane1, stripedLane2, stripedLane3;
    logic       stripedVLD;
    logic       laneRDY;
    logic [7:0] byteUnstripingOUT;
    logic       byteUnstripingVLD;
    logic       overflowERR;

    int checks   = 0;
    int failures = 0;

    always #5 clk1Mhz = ~clk1Mhz;

    byte_unstriping #(.DATA_WIDTH(8), .FIFO_DEPTH(2)) dut (
        .clk1Mhz           (clk1Mhz),
        .reset             (reset),
        .stripedLane0      (stripedLane0),
        .stripedLane1      (stripedLane1),
        .stripedLane2      (stripedLane2),
        .stripedLane3      (stripedLane3),
        .stripedVLD        (stripedVLD),
        .laneRDY           (laneRDY),
        .byteUnstripingOUT (byteUnstripingOUT),
        .byteUnstripingVLD (byteUnstripingVLD),
        .overflowERR       (overflowERR)
    );

    typedef struct {
        logic        vld;
        logic [31:0] word;
        logic        exp_vld;
        logic [7:0]  exp_out;
        logic        exp_rdy;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] w, logic ev, logic [7:0] eo,
                                logic er, logic ef);
        vec_t r;
        r.vld = v; r.word = w; r.exp_vld = ev; r.exp_out = eo;
        r.exp_rdy = er; r.exp_ovf = ef;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] w);
        stripedVLD   = v;
        stripedLane0 = w[7:0];
        stripedLane1 = w[15:8];
        stripedLane2 = w[23:16];
        stripedLane3 = w[31:24];
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic step();
        @(posedge clk1Mhz);
        #1;
    endtask

    task automatic check_out(string tag, logic ev, logic [7:0] eo, logic er, logic ef);
        check({tag, ".vld"}, 32'(byteUnstripingVLD), 32'(ev));
        check({tag, ".out"}, 32'(byteUnstripingOUT), 32'(eo));
        check({tag, ".rdy"}, 32'(laneRDY), 32'(er));
        check({tag, ".ovf"}, 32'(overflowERR), 32'(ef));
    endtask

    logic [7:0] stream [8];
    logic [7:0] got [$];
    int         first_cyc, last_cyc;

    initial begin
        // Single word, two words spaced 4 edges apart, overflow burst.
        tbl.push_back(mk(1, 32'hFFF00F00, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'h00, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'h0F, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'hF0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 32'hFFF00F00, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'h00, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'h0F, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'hF0, 1, 0));
        tbl.push_back(mk(1, 32'h000FF0FF, 1, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'hF0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'h0F, 1, 0));
        tbl.push_back(mk(0, 32'h0,        1, 8'h00, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 32'hA3A2A1A0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 32'hB3B2B1B0, 1, 8'hA0, 1, 0));
        tbl.push_back(mk(1, 32'hC3C2C1C0, 1, 8'hA1, 0, 0));
        tbl.push_back(mk(1, 32'hD3D2D1D0, 1, 8'hA2, 0, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hA3, 0, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hB0, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hB1, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hB2, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hB3, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hC0, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hC1, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hC2, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 8'hC3, 1, 1));
        tbl.push_back(mk(0, 32'h0,        0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 32'h0,        0, 8'h00, 1, 1));

        // Reset held two edges.
        reset = 1'b1;
        drive(1'b0, 32'h0);
        step();
        step();
        check_out("reset", 0, 8'h00, 1, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("idle%0d", i), 0, 8'h00, 1, 0);
        end

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].word);
            step();
            check_out($sformatf("vec%0d", i), tbl[i].exp_vld, tbl[i].exp_out,
                      tbl[i].exp_rdy, tbl[i].exp_ovf);
        end

        // Reset mid-word with a second word queued; overflowERR still set.
        drive(1'b1, 32'h13121110);
        step();
        check_out("rst_w1", 0, 8'h00, 1, 1);
        drive(1'b1, 32'h23222120);
        step();
        check_out("rst_l0", 1, 8'h10, 1, 1);
        drive(1'b0, 32'h0);
        step();
        check_out("rst_l1", 1, 8'h11, 1, 1);
        reset = 1'b1;
        drive(1'b1, 32'h99999999);   // must be ignored under reset
        step();
        check_out("rst_hit", 0, 8'h00, 1, 0);
        reset = 1'b0;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_out($sformatf("rst_quiet%0d", i), 0, 8'h00, 1, 0);
        end
        drive(1'b1, 32'h33323130);
        step();
        check_out("rst_new_nobypass", 0, 8'h00, 1, 0);
        drive(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("rst_new_b%0d", i), 1, 8'(8'h30 + i), 1, 0);
        end
        step();
        check_out("rst_new_end", 0, 8'h00, 1, 0);

        // Loopback: bench-side striper packs the stream into back-to-back words.
        stream[0] = 8'h00; stream[1] = 8'h0F; stream[2] = 8'hF0; stream[3] = 8'hFF;
        stream[4] = 8'hFF; stream[5] = 8'hF0; stream[6] = 8'h0F; stream[7] = 8'h00;
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 2)
                drive(1'b1, {stream[4*c+3], stream[4*c+2], stream[4*c+1], stream[4*c]});
            else
                drive(1'b0, 32'h0);
            step();
            if (byteUnstripingVLD) begin
                got.push_back(byteUnstripingOUT);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        check("loop.count", 32'(got.size()), 32'd8);
        check("loop.contig", 32'(last_cyc - first_cyc), 32'd7);
        check("loop.first_cyc", 32'(first_cyc), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size())
                check($sformatf("loop.b%0d", i), 32'(got[i]), 32'(stream[i]));
        end
        check("loop.ovf", 32'(overflowERR), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_unstriping.md
Name: byte_unstriping

Overview:
Receive-side counterpart of the 4-lane byte striper. It accepts one 4-byte word per handshake from the lane bus. Byte i of the original stream sits on lane i mod 4. The block re-serializes the word into a single byte stream, lane0 first. A small word FIFO decouples bursty lane arrivals from the 1-byte-per-clock output. This allows striper and de-striper to be chained for loopback tests.

Parameters:
DATA_WIDTH, 8, width of one lane / output byte
FIFO_DEPTH, 2, number of 4-lane words buffered (power of 2, >=2)

Ports:
clk1Mhz  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high; dominates all other inputs
stripedLane0  input  DATA_WIDTH  lane 0 byte (stream byte 4n+0)
stripedLane1  input  DATA_WIDTH  lane 1 byte (stream byte 4n+1)
stripedLane2  input  DATA_WIDTH  lane 2 byte (stream byte 4n+2)
stripedLane3  input  DATA_WIDTH  lane 3 byte (stream byte 4n+3)
stripedVLD  input  1  the four lanes carry a valid word this cycle
laneRDY  output  1  block can accept a word this cycle (FIFO not full)
byteUnstripingOUT  output  DATA_WIDTH  reassembled byte stream, registered
byteUnstripingVLD  output  1  byteUnstripingOUT valid this cycle, registered
overflowERR  output  1  sticky: a word was offered while laneRDY=0

Behaviour:
- Clock and reset: one clock, clk1Mhz. Reset is synchronous and active-high. While reset=1 at an edge, the following take effect:
  - FIFO emptied (pointers and count = 0); byte counter = 0; state = IDLE.
  - byteUnstripingOUT = 0, byteUnstripingVLD = 0, overflowERR = 0.
  - laneRDY = 1 from the first cycle after reset.
- Accept: a word is written on an edge where stripedVLD=1 and laneRDY=1. laneRDY = (count != FIFO_DEPTH), combinational from count.
- Overflow: stripedVLD=1 with laneRDY=0 drops the word. FIFO contents are unchanged and overflowERR is set. overflowERR stays set until reset.
- Simultaneous push and pop on one edge: count is unchanged and both pointers advance. When full, no push occurs that cycle because laneRDY=0, even if a pop happens on the same edge.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH.
- Serializer FSM:
  - IDLE: byteUnstripingVLD=0 and byteUnstripingOUT=0.
    - If the FIFO is non-empty at an edge, pop the head into the shift register. On that same edge drive lane0 with VLD=1, set cnt=1 and go to SEND.
  - SEND: each edge drives the lane selected by cnt (1, 2, 3) and increments cnt.
    - On the edge following lane3, if the FIFO is non-empty: pop the next word, drive its lane0, set cnt=1 and stay in SEND. There is no bubble between words.
    - Otherwise: go to IDLE and drop VLD to 0.
- Latency and throughput:
  - A word accepted at edge k shows lane0 after edge k+1 when the serializer is idle, then lane1..lane3 after edges k+2..k+4.
  - Sustained throughput is 1 word per 4 clocks. Input bursts up to FIFO_DEPTH words are absorbed.
- No bypass path: a word is never serialized on the same edge it is written.
- Reset during SEND aborts the word in flight; the remaining bytes are never emitted. Words still in the FIFO are discarded.
- Byte order is always lane0, lane1, lane2, lane3; there are no partial words.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0, laneRDY=1, no VLD for 5 idle cycles.
2. Single word L0..L3 = 00,0F,F0,FF accepted at edge k -> VLD=1 after edges k+1..k+4 with OUT = 00,0F,F0,FF, then VLD=0.
3. Two words at edges k and k+4: (00,0F,F0,FF) then (FF,F0,0F,00) -> 8 contiguous valid bytes 00,0F,F0,FF,FF,F0,0F,00 with no gap.
4. stripedVLD high on 4 consecutive edges, words A, B, C, D, FIFO_DEPTH=2:
   - A and B are accepted and A is popped at edge 1.
   - C is accepted at edge 2; the FIFO is now full and laneRDY=0.
   - D is dropped and overflowERR=1.
   - Output is 12 contiguous bytes A0..A3, B0..B3, C0..C3.
   - overflowERR stays 1 afterwards.
5. Reset asserted after lane1 of a word, with one more word queued -> next cycle OUT=0, VLD=0, overflowERR=0. The queued word is never output, and a new word afterwards serializes normally.
6. Loopback: byte stream 00,0F,F0,FF,FF,F0,0F,00 through the striper into this block -> identical byte sequence on byteUnstripingOUT.
